// File: rtl/sio_boot_loader.sv
// Serial boot loader: drives the SIO CPU-side bus while the CPU is held in reset.
// Commands: W addrH addrL len data.. -> checksum; R addrH addrL len -> data..; G -> 'K', release CPU.
module sio_boot_loader (
  input  logic        clk,
  input  logic        n_rst,
  output logic        sio_ce,
  output logic        sio_rd,
  output logic        sio_wr,
  output logic        sio_cd,
  output logic [7:0]  sio_dout,
  input  logic [7:0]  sio_din,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_n_rst,
  output logic        busy
);

  // Byte-level sequencer; phase records which command byte is being moved.
  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_CHECK, S_RD, S_CAP, S_WR, S_MEMW, S_MEMR, S_MEMCAP, S_RUN
  } state_t;

  typedef enum logic [3:0] {
    P_OP, P_AH, P_AL, P_LEN, P_WDATA, P_NAK, P_CSUM, P_RDATA, P_ACK, P_DRAIN
  } phase_t;

  state_t      state, state_d;
  phase_t      phase, phase_d;
  logic        cmd_w, cmd_w_d;
  logic [8:0]  cnt, cnt_d;
  logic [7:0]  csum, csum_d;
  logic [7:0]  rbyte, rbyte_d;
  logic [15:0] addr_d;
  logic [7:0]  wdata_d;
  logic        run_d;
  logic        is_get;
  logic [7:0]  tx_byte;
  logic        ce_d, rd_d, wr_d, cd_d, we_d, re_d, busy_d;
  logic [7:0]  dout_d;

  always_comb begin
    case (phase)
      P_NAK:   tx_byte = 8'h3F;
      P_CSUM:  tx_byte = csum;
      P_RDATA: tx_byte = rbyte;
      P_ACK:   tx_byte = 8'h4B;
      default: tx_byte = 8'h00;
    endcase
  end

  assign is_get = phase inside {P_OP, P_AH, P_AL, P_LEN, P_WDATA};

  always_comb begin
    state_d = state;
    phase_d = phase;
    cmd_w_d = cmd_w;
    cnt_d   = cnt;
    csum_d  = csum;
    rbyte_d = rbyte;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    run_d   = cpu_n_rst;
    case (state)
      S_IDLE: begin
        state_d = S_POLL;
        phase_d = P_OP;
      end
      S_POLL:  state_d = S_CHECK;
      // Status arrives one cycle after the POLL strobe: bit1 rx_ready, bit0 tx_ready.
      S_CHECK: begin
        if (is_get ? sio_din[1] : sio_din[0]) begin
          if (is_get) begin
            state_d = S_RD;
          end else if (phase == P_DRAIN) begin
            state_d = S_RUN;
            run_d   = 1'b1;
            addr_d  = 16'h0000;
            wdata_d = 8'h00;
          end else begin
            state_d = S_WR;
          end
        end else begin
          state_d = S_POLL;
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        state_d = S_POLL;
        case (phase)
          P_OP: begin
            csum_d = 8'h00;
            if (sio_din == 8'h57) begin
              cmd_w_d = 1'b1;
              phase_d = P_AH;
            end else if (sio_din == 8'h52) begin
              cmd_w_d = 1'b0;
              phase_d = P_AH;
            end else if (sio_din == 8'h47) begin
              phase_d = P_ACK;
            end else begin
              phase_d = P_NAK;
            end
          end
          P_AH: begin
            addr_d[15:8] = sio_din;
            phase_d      = P_AL;
          end
          P_AL: begin
            addr_d[7:0] = sio_din;
            phase_d     = P_LEN;
          end
          P_LEN: begin
            // A zero length byte encodes 256.
            cnt_d = {sio_din == 8'h00, sio_din};
            if (cmd_w) begin
              phase_d = P_WDATA;
            end else begin
              phase_d = P_RDATA;
              state_d = S_MEMR;
            end
          end
          P_WDATA: begin
            wdata_d = sio_din;
            csum_d  = csum + sio_din;
            state_d = S_MEMW;
          end
          default: ;
        endcase
      end
      S_MEMW: begin
        addr_d  = mem_addr + 16'd1;
        cnt_d   = cnt - 9'd1;
        state_d = S_POLL;
        phase_d = (cnt == 9'd1) ? P_CSUM : P_WDATA;
      end
      S_MEMR:   state_d = S_MEMCAP;
      S_MEMCAP: begin
        rbyte_d = mem_rdata;
        state_d = S_POLL;
      end
      S_WR: begin
        case (phase)
          P_RDATA: begin
            addr_d  = mem_addr + 16'd1;
            cnt_d   = cnt - 9'd1;
            state_d = (cnt == 9'd1) ? S_IDLE : S_MEMR;
          end
          P_ACK: begin
            state_d = S_POLL;
            phase_d = P_DRAIN;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so each lasts exactly one cycle.
    ce_d   = state_d inside {S_POLL, S_RD, S_WR};
    rd_d   = state_d inside {S_POLL, S_RD};
    wr_d   = (state_d == S_WR);
    cd_d   = (state_d == S_POLL);
    dout_d = (state_d == S_WR) ? tx_byte : 8'h00;
    we_d   = (state_d == S_MEMW);
    re_d   = (state_d == S_MEMR);
    busy_d = !(state_d inside {S_IDLE, S_RUN}) && !(phase_d inside {P_OP, P_DRAIN});
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      phase     <= P_OP;
      cmd_w     <= 1'b0;
      cnt       <= 9'd0;
      csum      <= 8'h00;
      rbyte     <= 8'h00;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      cpu_n_rst <= 1'b0;
      sio_ce    <= 1'b0;
      sio_rd    <= 1'b0;
      sio_wr    <= 1'b0;
      sio_cd    <= 1'b0;
      sio_dout  <= 8'h00;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      cmd_w     <= cmd_w_d;
      cnt       <= cnt_d;
      csum      <= csum_d;
      rbyte     <= rbyte_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      cpu_n_rst <= run_d;
      sio_ce    <= ce_d;
      sio_rd    <= rd_d;
      sio_wr    <= wr_d;
      sio_cd    <= cd_d;
      sio_dout  <= dout_d;
      mem_we    <= we_d;
      mem_re    <= re_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sio_boot_loader.sv
// Bench for sio_boot_loader: SIO and RAM models, expected-queue scoreboard, directed commands.
module tb_sio_boot_loader;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        sio_ce, sio_rd, sio_wr, sio_cd;
  logic [7:0]  sio_dout;
  logic [7:0]  sio_din = 8'h00;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        cpu_n_rst, busy;

  always #5 clk = ~clk;

  sio_boot_loader dut (
    .clk(clk), .n_rst(n_rst),
    .sio_ce(sio_ce), .sio_rd(sio_rd), .sio_wr(sio_wr), .sio_cd(sio_cd),
    .sio_dout(sio_dout), .sio_din(sio_din),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .cpu_n_rst(cpu_n_rst), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ce_seen  = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [23:0] exp_we_q[$];
  logic [15:0] exp_re_q[$];
  logic [7:0]  ram [0:65535];

  logic tx_ready  = 1'b1;
  int   tx_hold   = 2;
  int   hold_cnt  = 0;
  logic after_k   = 1'b0;
  int   shown_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  // SIO and RAM models; SIO read data appears the cycle after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
    if (sio_ce && sio_rd && sio_cd) begin
      sio_din <= {6'b0, rx_q.size() != 0, tx_ready};
      if (after_k && tx_ready && shown_cyc == 0) shown_cyc <= cyc + 1;
    end else if (sio_ce && sio_rd) begin
      if (rx_q.size() != 0) sio_din <= rx_q.pop_front();
      else sio_din <= 8'h00;
    end
    if (sio_ce && sio_wr) begin
      tx_ready <= 1'b0;
      hold_cnt <= tx_hold;
      if (sio_dout == 8'h4B) after_k <= 1'b1;
    end else if (!tx_ready) begin
      if (hold_cnt == 0) tx_ready <= 1'b1;
      else hold_cnt <= hold_cnt - 1;
    end
  end

  // Monitor: every DUT-presented transfer is popped against its expected queue.
  always @(negedge clk) begin
    if (n_rst) begin
      if (sio_ce) begin
        ce_seen++;
        check("rd_wr_exclusive", 32'(sio_rd & sio_wr), 32'd0);
      end
      if (sio_ce && sio_wr) begin
        if (exp_tx_q.size() == 0) unexpected("tx_byte", 32'(sio_dout));
        else check("tx_byte", 32'(sio_dout), 32'(exp_tx_q.pop_front()));
      end
      if (mem_we) begin
        if (exp_we_q.size() == 0) unexpected("mem_we", 32'({mem_addr, mem_wdata}));
        else check("mem_we_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_we_q.pop_front()));
      end
      if (mem_re) begin
        if (exp_re_q.size() == 0) unexpected("mem_re", 32'(mem_addr));
        else check("mem_re_addr", 32'(mem_addr), 32'(exp_re_q.pop_front()));
      end
    end
  end

  task automatic wait_drain(input string name, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(posedge clk); #2;
      if (exp_tx_q.size() == 0 && exp_we_q.size() == 0 && exp_re_q.size() == 0 &&
          rx_q.size() == 0 && !busy) break;
    end
    check({name, "_completed"}, 32'(i < max_cyc), 32'd1);
  endtask

  task automatic wait_poll(input string name);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sio_ce) break;
    end
    check({name, "_strobe_seen"}, 32'(i < 20), 32'd1);
    check({name, "_is_status_poll"}, 32'({sio_rd, sio_wr, sio_cd}), 32'b101);
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  initial begin
    int k;
    int ce0;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_sio_ce", 32'(sio_ce), 32'd0);
    check("rst_sio_rd", 32'(sio_rd), 32'd0);
    check("rst_sio_wr", 32'(sio_wr), 32'd0);
    check("rst_sio_cd", 32'(sio_cd), 32'd0);
    check("rst_sio_dout", 32'(sio_dout), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_mem_strobes", 32'({mem_we, mem_re}), 32'd0);
    check("rst_cpu_n_rst", 32'(cpu_n_rst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    n_rst = 1'b1;
    wait_poll("first_poll");

    // Write three bytes; checksum AA+BB+CC = 0x231 -> 0x31.
    exp_we_q.push_back({16'h1234, 8'hAA});
    exp_we_q.push_back({16'h1235, 8'hBB});
    exp_we_q.push_back({16'h1236, 8'hCC});
    exp_tx_q.push_back(8'h31);
    send(8'h57); send(8'h12); send(8'h34); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    wait_drain("write", 400);
    check("write_ram_1236", 32'(ram[16'h1236]), 32'hCC);

    // Read across the address wrap.
    ram[16'hFFFF] = 8'h5A;
    ram[16'h0000] = 8'hA5;
    exp_re_q.push_back(16'hFFFF);
    exp_re_q.push_back(16'h0000);
    exp_tx_q.push_back(8'h5A);
    exp_tx_q.push_back(8'hA5);
    send(8'h52); send(8'hFF); send(8'hFF); send(8'h02);
    wait_drain("read_wrap", 400);

    // Length byte 0 means 256; checksum of 256 ones is 0x00.
    for (int i = 0; i < 256; i++) exp_we_q.push_back({16'h8000 + 16'(i), 8'h01});
    exp_tx_q.push_back(8'h00);
    send(8'h57); send(8'h80); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'h01);
    wait_drain("len256", 5000);
    check("len256_ram_80ff", 32'(ram[16'h80FF]), 32'h01);

    // Unknown opcode, then a normal one-byte read of 0x0000 (holds 0xA5).
    exp_tx_q.push_back(8'h3F);
    exp_re_q.push_back(16'h0000);
    exp_tx_q.push_back(8'hA5);
    send(8'h41);
    send(8'h52); send(8'h00); send(8'h00); send(8'h01);
    wait_drain("unknown_then_read", 400);

    // Reset in the middle of a W payload.
    exp_we_q.push_back({16'h2000, 8'h11});
    exp_we_q.push_back({16'h2001, 8'h22});
    send(8'h57); send(8'h20); send(8'h00); send(8'h04);
    send(8'h11); send(8'h22);
    for (k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      if (exp_we_q.size() == 0 && rx_q.size() == 0) break;
    end
    check("midw_payload_reached", 32'(k < 400), 32'd1);
    repeat (10) @(posedge clk);
    #2;
    check("midw_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("midw_rst_strobes", 32'({sio_ce, sio_rd, sio_wr, mem_we, mem_re}), 32'd0);
    check("midw_rst_cpu_n_rst", 32'(cpu_n_rst), 32'd0);
    check("midw_rst_busy", 32'(busy), 32'd0);
    rx_q.delete();
    repeat (2) @(posedge clk);
    #2;
    check("midw_ram_kept", 32'({ram[16'h2000], ram[16'h2001]}), 32'h1122);
    n_rst = 1'b1;
    wait_poll("midw_post_rst_poll");

    // Go with transmitter back-pressure after the K.
    tx_hold = 20;
    exp_tx_q.push_back(8'h4B);
    send(8'h47);
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (exp_tx_q.size() == 0) break;
    end
    check("go_k_sent", 32'(k < 200), 32'd1);
    repeat (10) @(posedge clk);
    #2;
    check("go_cpu_held", 32'(cpu_n_rst), 32'd0);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cpu_n_rst) break;
    end
    check("go_cpu_released", 32'(k < 100), 32'd1);
    check("go_release_cycle", 32'(cyc), 32'(shown_cyc + 1));

    ce0 = ce_seen;
    send(8'h57); send(8'h00); send(8'h00);
    repeat (50) @(posedge clk);
    #2;
    check("run_ce_quiet", 32'(ce_seen), 32'(ce0));
    check("run_rx_untouched", 32'(rx_q.size()), 32'd3);
    check("run_outputs_zero", 32'({mem_addr, mem_wdata, busy}), 32'd0);
    check("run_cpu_n_rst", 32'(cpu_n_rst), 32'd1);

    @(negedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("run_async_rst_cpu", 32'(cpu_n_rst), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
